datamem: RTL and testbench
==========================

Name:
datamem

Overview:
- Block-granular backing data memory behind the write-back data cache.
- Stores whole cache lines and returns them on request: the addressed line on `out1`, the following line on `out2`.
- Accepts whole-line write-backs of dirty lines evicted by the cache.
- A flush request freezes the memory image for end-of-run dump and reports completion.

Parameters:
- WORD_SIZE, 32, address width in bits.
- BLOCK_SIZE, 1024, line width in bits (128 bytes). Byte offset 0 occupies bits [BLOCK_SIZE-1:BLOCK_SIZE-8], i.e. MSB-first.
- OFFSET_LEN, 7, byte-offset bits within a line (log2 of BLOCK_SIZE/8).
- DEPTH, 64, number of lines stored; must be a power of two.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- in  in  WORD_SIZE  byte address. Line number = in[WORD_SIZE-1:OFFSET_LEN] modulo DEPTH; in[OFFSET_LEN-1:0] is ignored.
- readable  in  1  read request.
- writable  in  1  write request (whole line).
- write  in  BLOCK_SIZE  line data to store.
- out1  out  BLOCK_SIZE  data of the addressed line.
- out2  out  BLOCK_SIZE  data of line (addressed line + 1) modulo DEPTH, for words straddling a line boundary.
- flush  in  1  flush/halt request.
- flush_done  out  1  sticky flush-complete flag.

Behaviour:
- Storage: DEPTH x BLOCK_SIZE array, all zero at power-up. Reset does not alter array contents.
- Reset (rst=1 at a rising edge):
  - out1 = 0, out2 = 0, flush_done = 0.
  - A pending read or write in the same cycle is discarded.
- Line index: L = in[OFFSET_LEN+log2(DEPTH)-1:OFFSET_LEN]. Higher address bits alias; no error is raised.
- Write (writable=1, rst=0, flush_done=0): mem[L] <= write at the rising edge. Partial writes are not supported.
- Read (readable=1, rst=0) at a rising edge:
  - out1 <= mem[L]; out2 <= mem[(L+1) mod DEPTH].
  - Data is valid the cycle after the request, so latency is 1 clock.
  - Outputs hold their value until the next read or reset.
- Read and write together in one cycle, same line: read-before-write. out1 returns the old contents; the new data is visible to the next read. The same rule applies to out2 when the write hits line L+1.
- Wrap: reading line DEPTH-1 returns line 0 on out2.
- No handshake/ready: every request completes in one cycle. The requester may hold readable/writable high for multiple cycles; each cycle is a new access (repeated writes are idempotent).
- Flush:
  - At the first rising edge with flush=1 and rst=0, flush_done <= 1 (1-cycle latency).
  - flush_done stays 1 until reset.
  - While flush_done=1, writes are ignored and the image is frozen. Reads still work.
  - A write in the same cycle as the first flush=1 edge still commits, so the final write-back preceding flush is kept.
- Deasserting flush has no effect.
- Unknown (X) request inputs are treated as 0.

Test Plan:
- After reset, read in=0x00000000 -> next cycle out1=0, out2=0, flush_done=0.
- Write line 0x00000080 with pattern A (0xDEAD... repeated) -> read in=0x000000C5 (same line, offset ignored) -> out1=A. Read in=0x00000000 -> out2=A.
- Write line 63 (in=0x00001F80) with B and line 0 with C -> read in=0x00001F80 -> out1=B, out2=C (wrap). Read in=0x00003F80 (aliases line 63) -> out1=B.
- Same-cycle read+write of line 2, old=D, new=E -> out1=D. A following read -> E.
- Write F to line 5 together with the first flush=1 -> flush_done=1 next cycle. Then write G to line 5 -> read returns F. Assert rst -> flush_done=0, and read of line 5 still returns F.
- Reset asserted during a write of line 7 -> the write is discarded (read returns prior value); out1/out2 = 0 after reset.

Source files
------------

// File: rtl/datamem.sv
// Line-granular backing store behind the write-back data cache.
// Returns the addressed line and its successor; a flush freezes the image until reset.
module datamem #(
  parameter int WORD_SIZE  = 32,
  parameter int BLOCK_SIZE = 1024,
  parameter int OFFSET_LEN = 7,
  parameter int DEPTH      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WORD_SIZE-1:0]  in,
  input  logic                  readable,
  input  logic                  writable,
  input  logic [BLOCK_SIZE-1:0] write,
  output logic [BLOCK_SIZE-1:0] out1,
  output logic [BLOCK_SIZE-1:0] out2,
  input  logic                  flush,
  output logic                  flush_done
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BLOCK_SIZE-1:0] mem_q [DEPTH] = '{default: '0};

  logic [IDX_W-1:0]      line_idx;
  logic [IDX_W-1:0]      next_idx;
  logic                  rd_en;
  logic                  wr_en;

  logic [BLOCK_SIZE-1:0] out1_q, out1_d;
  logic [BLOCK_SIZE-1:0] out2_q, out2_d;
  logic                  flush_done_q, flush_done_d;

  // Upper address bits alias; the successor index wraps naturally at DEPTH.
  assign line_idx = in[OFFSET_LEN+IDX_W-1:OFFSET_LEN];
  assign next_idx = line_idx + 1'b1;

  assign rd_en = (readable == 1'b1);
  assign wr_en = (writable == 1'b1) && !flush_done_q && !rst;

  always_comb begin
    out1_d       = out1_q;
    out2_d       = out2_q;
    flush_done_d = flush_done_q;
    if (rd_en) begin
      out1_d = mem_q[line_idx];
      out2_d = mem_q[next_idx];
    end
    if (flush == 1'b1) begin
      flush_done_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out1_q       <= '0;
      out2_q       <= '0;
      flush_done_q <= 1'b0;
    end else begin
      out1_q       <= out1_d;
      out2_q       <= out2_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Reads above sample the pre-edge contents, giving read-before-write on a shared line.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[line_idx] <= write;
    end
  end

  assign out1       = out1_q;
  assign out2       = out2_q;
  assign flush_done = flush_done_q;

endmodule

// File: tb/tb_datamem.sv
// Directed bench for datamem: vector table for read/write/wrap/alias cases,
// hand sequences for flush freeze and reset-during-write.
module tb_datamem;

  localparam int BW = 1024;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   in;
  logic          readable;
  logic          writable;
  logic [BW-1:0] write;
  logic [BW-1:0] out1;
  logic [BW-1:0] out2;
  logic          flush;
  logic          flush_done;

  int total = 0;
  int bad   = 0;

  datamem dut (
    .clk        (clk),
    .rst        (rst),
    .in         (in),
    .readable   (readable),
    .writable   (writable),
    .write      (write),
    .out1       (out1),
    .out2       (out2),
    .flush      (flush),
    .flush_done (flush_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rs;
    logic          rd;
    logic          wr;
    logic          fl;
    logic [31:0]   addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] e1;
    logic [BW-1:0] e2;
    logic          efd;
  } vec_t;

  localparam int NV = 13;
  vec_t vecs [NV];

  logic [BW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f, pat_g, pat_h, pat_i, zero;

  task automatic check_line(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got[127:0]=%h want[127:0]=%h", name, got[127:0], exp[127:0]);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%b want=%b", name, got, exp);
    end
  endtask

  task automatic drive(input logic rs_v, input logic rd_v, input logic wr_v, input logic fl_v,
                       input logic [31:0] a, input logic [BW-1:0] d);
    rst      = rs_v;
    readable = rd_v;
    writable = wr_v;
    flush    = fl_v;
    in       = a;
    write    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero  = '0;
    pat_a = {32{32'hDEADBEEF}};
    pat_b = {32{32'hB0B00001}};
    pat_c = {32{32'hC0C00002}};
    pat_d = {32{32'hD0D00003}};
    pat_e = {32{32'hE0E00004}};
    pat_f = {32{32'hF0F00005}};
    pat_g = {32{32'h60600006}};
    pat_h = {32{32'h70700007}};
    pat_i = {32{32'h80800008}};

    //            rs    rd    wr    fl    addr          wdata  out1   out2   fd
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, zero,  zero,  zero,  1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, zero,  zero,  zero,  1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000080, pat_a, zero,  zero,  1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h000000C5, zero,  pat_a, zero,  1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000000, zero,  zero,  pat_a, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00001F80, pat_b, zero,  pat_a, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000000, pat_c, zero,  pat_a, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00001F80, zero,  pat_b, pat_c, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00003F80, zero,  pat_b, pat_c, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 32'h00000100, pat_d, pat_b, pat_c, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h00000100, pat_e, pat_d, zero,  1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000100, zero,  pat_e, zero,  1'b0};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00000080, zero,  pat_a, pat_e, 1'b0};

    rst = 1'b1; readable = 1'b0; writable = 1'b0; flush = 1'b0; in = '0; write = '0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rs, vecs[i].rd, vecs[i].wr, vecs[i].fl, vecs[i].addr, vecs[i].wdata);
      check_line($sformatf("vec%0d_out1", i), out1, vecs[i].e1);
      check_line($sformatf("vec%0d_out2", i), out2, vecs[i].e2);
      check_bit ($sformatf("vec%0d_fd", i), flush_done, vecs[i].efd);
    end

    // Write committed on the same edge that first sees flush.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 32'h00000280, pat_f);
    check_bit("flush_set", flush_done, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00000280, pat_g);
    check_bit("flush_sticky", flush_done, 1'b1);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000280, zero);
    check_line("frozen_out1", out1, pat_f);
    check_line("frozen_out2", out2, zero);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00000240, pat_g);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000240, zero);
    check_line("frozen_line4_out1", out1, zero);
    check_line("frozen_line4_out2", out2, pat_f);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h00000000, zero);
    check_bit("flush_cleared", flush_done, 1'b0);
    check_line("rst_out1", out1, zero);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000280, zero);
    check_line("after_rst_line5", out1, pat_f);

    // Writes resume after reset; a write under reset is dropped.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h00000380, pat_h);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000340, zero);
    check_line("line6_out1", out1, zero);
    check_line("line7_via_out2", out2, pat_h);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h00000380, pat_i);
    check_line("rstw_out1", out1, zero);
    check_line("rstw_out2", out2, zero);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h00000380, zero);
    check_line("idle_hold", out1, zero);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h00000380, zero);
    check_line("rstw_discarded", out1, pat_h);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h00000000, zero);
    check_line("hold_out1", out1, pat_h);
    check_bit("final_fd", flush_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
